// File: rtl/fft_stream_packer.sv
`default_nettype none
// ============================================================================
// Module      : fft_stream_packer
// Description : Packs a continuous complex ADC sample stream into fixed-length
//               Avalon-ST frames for the FFT core.
//               - Samples are buffered in a small first-word-fall-through FIFO.
//               - Output frames are exactly FFT_LEN beats long and carry sop/eop.
//               - The FFT's ready backpressure is honoured.
//               - Frames that lost samples are flagged on their eop beat.
// Ports       : clk_i, reset_i                  clock, synchronous active-high reset
//               enable_i                        capture enable (acted on at frame starts/ends)
//               adc_valid_i, adc_real_i,
//               adc_imag_i                      ADC sample input
//               src_ready_i                     FFT sink ready
//               src_valid_o, src_sop_o,
//               src_eop_o, src_data_o,
//               src_error_o                     Avalon-ST source to the FFT
//               overflow_o                      sticky sample-drop flag
//               frame_cnt_o                     delivered-frame counter
// Revision    : 1.0 - initial release
// ============================================================================
module fft_stream_packer #(
    parameter int FFT_LEN    = 1024,
    parameter int FIFO_DEPTH = 16
) (
    input  logic        clk_i,
    input  logic        reset_i,
    input  logic        enable_i,
    input  logic        adc_valid_i,
    input  logic [15:0] adc_real_i,
    input  logic [15:0] adc_imag_i,
    input  logic        src_ready_i,
    output logic        src_valid_o,
    output logic        src_sop_o,
    output logic        src_eop_o,
    output logic [31:0] src_data_o,
    output logic [1:0]  src_error_o,
    output logic        overflow_o,
    output logic [15:0] frame_cnt_o
);

    localparam int CNT_W = $clog2(FFT_LEN);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int OCC_W = $clog2(FIFO_DEPTH + 1);

    localparam logic [CNT_W-1:0] LAST_SLOT = CNT_W'(FFT_LEN - 1);
    localparam logic [OCC_W-1:0] OCC_FULL  = OCC_W'(FIFO_DEPTH);

    typedef enum logic [0:0] {
        ST_IDLE    = 1'b0,
        ST_CAPTURE = 1'b1
    } state_t;

    state_t             state_q;
    logic [CNT_W-1:0]   in_cnt_q;
    logic [CNT_W-1:0]   out_cnt_q;
    logic [31:0]        mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0]   wr_ptr_q;
    logic [PTR_W-1:0]   rd_ptr_q;
    logic [OCC_W-1:0]   count_q;
    logic               lost_q;
    logic               overflow_q;
    logic [15:0]        frame_cnt_q;

    logic fifo_full;
    logic fifo_empty;
    logic rd_en;
    logic slot;
    logic wr_en;
    logic drop;
    logic eop_now;
    logic eop_xfer;

    assign fifo_full  = (count_q == OCC_FULL);
    assign fifo_empty = (count_q == '0);
    assign rd_en      = !fifo_empty && src_ready_i;

    // In IDLE only an enabled sample opens a frame; once capturing, every
    // valid sample occupies a slot so a frame is never truncated.
    assign slot  = adc_valid_i && ((state_q == ST_CAPTURE) || enable_i);

    // A full FIFO still accepts a write when the head leaves in the same cycle.
    assign wr_en = slot && (!fifo_full || rd_en);
    assign drop  = slot && fifo_full && !rd_en;

    assign eop_now  = (out_cnt_q == LAST_SLOT);
    assign eop_xfer = rd_en && eop_now;

    // Input framing FSM and slot counter. Both counters are powers of two,
    // so natural binary wrap gives the modulo-FFT_LEN behaviour.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q  <= ST_IDLE;
            in_cnt_q <= '0;
        end else if (slot) begin
            in_cnt_q <= in_cnt_q + 1'b1;
            case (state_q)
                ST_IDLE:    state_q <= ST_CAPTURE;
                ST_CAPTURE: if ((in_cnt_q == LAST_SLOT) && !enable_i) state_q <= ST_IDLE;
                default:    state_q <= ST_IDLE;
            endcase
        end
    end

    // Sample storage; contents need no reset because occupancy gates the output.
    always_ff @(posedge clk_i) begin
        if (wr_en) begin
            mem_q[wr_ptr_q] <= {adc_imag_i, adc_real_i};
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (wr_en) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (rd_en) rd_ptr_q <= rd_ptr_q + 1'b1;
            case ({wr_en, rd_en})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    // Output framing and status. Framing follows delivered beats only; a frame
    // that lost data is reported through src_error on its eop beat.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            out_cnt_q   <= '0;
            lost_q      <= 1'b0;
            overflow_q  <= 1'b0;
            frame_cnt_q <= '0;
        end else begin
            if (rd_en)    out_cnt_q   <= out_cnt_q + 1'b1;
            if (eop_xfer) frame_cnt_q <= frame_cnt_q + 1'b1;
            if (drop) begin
                overflow_q <= 1'b1;
                lost_q     <= 1'b1;
            end else if (eop_xfer) begin
                lost_q     <= 1'b0;
            end
        end
    end

    assign src_valid_o = !fifo_empty;
    assign src_data_o  = fifo_empty ? 32'd0 : mem_q[rd_ptr_q];
    assign src_sop_o   = !fifo_empty && (out_cnt_q == '0);
    assign src_eop_o   = !fifo_empty && eop_now;
    assign src_error_o = {1'b0, !fifo_empty && eop_now && lost_q};
    assign overflow_o  = overflow_q;
    assign frame_cnt_o = frame_cnt_q;

endmodule
`default_nettype wire
